alu_seq: RTL and testbench

- Parametrised, registered successor to the datapath ALU; adds an iterative unsigned multiply/divide path behind a valid/ready handshake.
- Sits in the EX stage; the decoder/hazard unit stalls on ready_o low.
- Simple ops complete in 1 cycle; MULU/DIVU/REMU take WIDTH+1 cycles.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_muldiv_iter.sv | 115 +++++++++++
 rtl/alu_seq.sv | 105 ++++++++++
 tb/tb_alu_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - 4-bit opcode encodings (AND..REMU, ZERO)
//   - iterative unit state encoding (IDLE/MUL/DIV)
//   - is_multicycle(): true for ops routed through the iterative unit
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_NAND = 4'd2;
  localparam logic [3:0] OP_NOR  = 4'd3;
  localparam logic [3:0] OP_ADDU = 4'd4;
  localparam logic [3:0] OP_SUBU = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SRAV = 4'd9;
  localparam logic [3:0] OP_LUI  = 4'd10;
  localparam logic [3:0] OP_SLTU = 4'd11;
  localparam logic [3:0] OP_MULU = 4'd12;
  localparam logic [3:0] OP_DIVU = 4'd13;
  localparam logic [3:0] OP_REMU = 4'd14;
  localparam logic [3:0] OP_ZERO = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  function automatic logic is_multicycle(input logic [3:0] op);
    is_multicycle = (op == OP_MULU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative unsigned multiply / restoring divide.
// Ports:
//   clk_i, rst_n   clock, async active-low reset
//   start_i        load operands and begin (only sampled in IDLE)
//   op_i           OP_MULU / OP_DIVU / OP_REMU
//   a_i, b_i       operands
//   done_o         high during the last iteration cycle
//   result_o       value valid while done_o is high (post-final-step)
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  // MUL: accumulator / multiplicand / multiplier
  // DIV: remainder   / dividend->quotient / divisor
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             rem_sel_q;

  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] addend_s;

  // One iteration step of whichever operation is in flight
  always_comb begin
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    addend_s = opb_q[0] ? opa_q : {WIDTH{1'b0}};
    rem_sh_s = {acc_q, opa_q[WIDTH-1]};
    diff_s   = rem_sh_s - {1'b0, opb_q};
    if (state_q == ST_MUL) begin
      acc_d = acc_q + addend_s;
      opa_d = opa_q << 1;
      opb_d = opb_q >> 1;
    end else if (state_q == ST_DIV) begin
      // Restore when the trial subtraction borrows (diff negative)
      if (!diff_s[WIDTH]) begin
        acc_d = diff_s[WIDTH-1:0];
      end else begin
        acc_d = rem_sh_s[WIDTH-1:0];
      end
      opa_d = {opa_q[WIDTH-2:0], ~diff_s[WIDTH]};
    end else begin
      acc_d = acc_q;
    end
  end

  // Result tap on the final step so the top can register it the same edge
  always_comb begin
    if (state_q == ST_MUL) begin
      result_o = acc_d;
    end else if (rem_sel_q) begin
      result_o = acc_d;
    end else begin
      result_o = opa_d;
    end
  end

  assign done_o = (state_q != ST_IDLE) && (cnt_q == CW'(1));

  // Iteration FSM, counter and datapath registers
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      rem_sel_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q   <= (op_i == OP_MULU) ? ST_MUL : ST_DIV;
            cnt_q     <= CW'(WIDTH);
            acc_q     <= '0;
            opa_q     <= a_i;
            opb_q     <= b_i;
            rem_sel_q <= (op_i == OP_REMU);
          end
        end
        ST_MUL, ST_DIV: begin
          acc_q <= acc_d;
          opa_q <= opa_d;
          opb_q <= opb_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with iterative MULU/DIVU/REMU behind valid/ready.
// Ports:
//   clk_i, rst_n     clock, async active-low reset
//   valid_i/ready_o  request handshake (accept on valid_i & ready_o)
//   ctrl_i           opcode (see alu_pkg)
//   src1_i, src2_i   operands A, B
//   result_o, zero_o result and result==0, held until next completion
//   valid_o          one-cycle completion pulse
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             valid_o
);

  localparam int SHW = $clog2(WIDTH);

  logic             ready_q, valid_q, zero_q;
  logic [WIDTH-1:0] result_q;

  logic             accept_s, div0_s, start_s, simple_s;
  logic [WIDTH-1:0] simple_res_s;
  logic             md_done_s;
  logic [WIDTH-1:0] md_result_s;

  assign accept_s = valid_i & ready_q;
  // Divide by zero never enters the iterative unit
  assign div0_s   = ((ctrl_i == OP_DIVU) || (ctrl_i == OP_REMU)) && (src2_i == {WIDTH{1'b0}});
  assign start_s  = accept_s & is_multicycle(ctrl_i) & ~div0_s;
  assign simple_s = accept_s & ~start_s;

  // Single-cycle result (also covers divide-by-zero)
  always_comb begin
    simple_res_s = {WIDTH{1'b0}};
    case (ctrl_i)
      OP_AND:  simple_res_s = src1_i & src2_i;
      OP_OR:   simple_res_s = src1_i | src2_i;
      OP_NAND: simple_res_s = ~(src1_i & src2_i);
      OP_NOR:  simple_res_s = ~(src1_i | src2_i);
      OP_ADDU: simple_res_s = src1_i + src2_i;
      OP_SUBU: simple_res_s = src1_i - src2_i;
      OP_SLT:  simple_res_s = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      OP_EQ:   simple_res_s = {{(WIDTH-1){1'b0}}, (src1_i == src2_i)};
      OP_SRA, OP_SRAV:
               simple_res_s = $signed(src1_i) >>> src2_i[SHW-1:0];
      OP_LUI:  simple_res_s = {src2_i[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLTU: simple_res_s = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
      OP_DIVU: simple_res_s = {WIDTH{1'b1}};
      OP_REMU: simple_res_s = src1_i;
      default: simple_res_s = {WIDTH{1'b0}};
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .start_i  (start_s),
    .op_i     (ctrl_i),
    .a_i      (src1_i),
    .b_i      (src2_i),
    .done_o   (md_done_s),
    .result_o (md_result_s)
  );

  // Output registers; simple completion and iterative completion never
  // coincide because ready is low for the whole iteration
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      if (simple_s) begin
        result_q <= simple_res_s;
        zero_q   <= (simple_res_s == {WIDTH{1'b0}});
        valid_q  <= 1'b1;
      end else if (md_done_s) begin
        result_q <= md_result_s;
        zero_q   <= (md_result_s == {WIDTH{1'b0}});
        valid_q  <= 1'b1;
        ready_q  <= 1'b1;
      end else if (start_s) begin
        ready_q  <= 1'b0;
      end
    end
  end

  assign ready_o  = ready_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign zero_o   = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed + random checks of alu_seq (WIDTH=32 and WIDTH=8)
// against an arithmetic reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [3:0]  ctrl_i = 4'd0;
  logic [31:0] src1_i = 32'd0, src2_i = 32'd0;
  logic        ready_o, zero_o, valid_o;
  logic [31:0] result_o;

  logic        v8 = 1'b0;
  logic [3:0]  c8 = 4'd0;
  logic [7:0]  a8 = 8'd0, b8 = 8'd0;
  logic        r8_rdy, r8_zero, r8_vld;
  logic [7:0]  r8_res;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .ctrl_i(ctrl_i), .src1_i(src1_i), .src2_i(src2_i),
    .result_o(result_o), .zero_o(zero_o), .valid_o(valid_o)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_n(rst_n), .valid_i(v8), .ready_o(r8_rdy),
    .ctrl_i(c8), .src1_i(a8), .src2_i(b8),
    .result_o(r8_res), .zero_o(r8_zero), .valid_o(r8_vld)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    r = 32'd0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = ~(a & b);
      4'd3:  r = ~(a | b);
      4'd4:  r = a + b;
      4'd5:  r = a - b;
      4'd6:  if ($signed(a) < $signed(b)) r = 32'd1; else r = 32'd0;
      4'd7:  if (a == b) r = 32'd1; else r = 32'd0;
      4'd8, 4'd9: r = $signed(a) >>> b[4:0];
      4'd10: r = {b[15:0], 16'h0000};
      4'd11: if (a < b) r = 32'd1; else r = 32'd0;
      4'd12: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      4'd13: if (b == 32'd0) r = 32'hFFFF_FFFF; else r = a / b;
      4'd14: if (b == 32'd0) r = a; else r = a % b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Issue one op on the 32-bit DUT and check latency, busy span, result, hold.
  // Entered and left at #1 after a rising edge.
  task automatic run32(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat, busy, exp_lat, exp_busy;
    logic [31:0] exp;
    exp = ref32(op, a, b);
    if ((op == 4'd12) || (((op == 4'd13) || (op == 4'd14)) && (b != 32'd0))) begin
      exp_lat = 33; exp_busy = 32;
    end else begin
      exp_lat = 1; exp_busy = 0;
    end
    check({tag, ".rdy_pre"}, {63'd0, ready_o}, 64'd1);
    valid_i = 1'b1; ctrl_i = op; src1_i = a; src2_i = b;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 1; busy = 0;
    while (!valid_o && lat < 200) begin
      if (!ready_o) busy++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    check({tag, ".busy"}, 64'(busy), 64'(exp_busy));
    check({tag, ".rdy"}, {63'd0, ready_o}, 64'd1);
    check({tag, ".res"}, {32'd0, result_o}, {32'd0, exp});
    check({tag, ".zero"}, {63'd0, zero_o}, {63'd0, (exp == 32'd0)});
    @(posedge clk); #1;
    check({tag, ".pulse"}, {63'd0, valid_o}, 64'd0);
    check({tag, ".hold"}, {32'd0, result_o}, {32'd0, exp});
  endtask

  logic [3:0]  b2b_op  [4];
  logic [31:0] b2b_a   [4];
  logic [31:0] b2b_b   [4];
  logic [31:0] b2b_exp [4];

  initial begin
    int pulses, lat;
    logic [3:0] rop;
    logic [31:0] ra, rb;

    #12;
    // reset values while held in reset
    check("rst.rdy", {63'd0, ready_o}, 64'd1);
    check("rst.vld", {63'd0, valid_o}, 64'd0);
    check("rst.res", {32'd0, result_o}, 64'd0);
    check("rst.zero", {63'd0, zero_o}, 64'd1);
    check("rst8.res", {56'd0, r8_res}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run32("addu_wrap", 4'd4, 32'hFFFF_FFFF, 32'd1);
    run32("subu", 4'd5, 32'd5, 32'd7);

    // back-to-back simple ops, one result per cycle
    b2b_op[0] = 4'd6;  b2b_a[0] = 32'hFFFF_FFFF; b2b_b[0] = 32'd1; b2b_exp[0] = 32'd1;
    b2b_op[1] = 4'd11; b2b_a[1] = 32'hFFFF_FFFF; b2b_b[1] = 32'd1; b2b_exp[1] = 32'd0;
    b2b_op[2] = 4'd8;  b2b_a[2] = 32'h8000_0000; b2b_b[2] = 32'd4; b2b_exp[2] = 32'hF800_0000;
    b2b_op[3] = 4'd10; b2b_a[3] = 32'hDEAD_BEEF; b2b_b[3] = 32'h0000_1234; b2b_exp[3] = 32'h1234_0000;
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; ctrl_i = b2b_op[i]; src1_i = b2b_a[i]; src2_i = b2b_b[i];
      @(posedge clk); #1;
      check($sformatf("b2b%0d.vld", i), {63'd0, valid_o}, 64'd1);
      check($sformatf("b2b%0d.res", i), {32'd0, result_o}, {32'd0, b2b_exp[i]});
    end
    valid_i = 1'b0;
    @(posedge clk); #1;

    run32("mulu", 4'd12, 32'h0001_0001, 32'h0001_0001);
    run32("divu", 4'd13, 32'd100, 32'd7);
    run32("remu", 4'd14, 32'd100, 32'd7);
    run32("divu0", 4'd13, 32'd9, 32'd0);
    run32("remu0", 4'd14, 32'd9, 32'd0);

    // asynchronous reset in the middle of a MULU
    valid_i = 1'b1; ctrl_i = 4'd12; src1_i = 32'd12345; src2_i = 32'd678;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort.rdy", {63'd0, ready_o}, 64'd1);
    check("abort.vld", {63'd0, valid_o}, 64'd0);
    check("abort.res", {32'd0, result_o}, 64'd0);
    check("abort.zero", {63'd0, zero_o}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid_o) pulses++;
    end
    check("abort.nopulse", 64'(pulses), 64'd0);
    run32("post_rst", 4'd4, 32'd2, 32'd3);

    // WIDTH=8: MULU with a second request held across the busy window
    v8 = 1'b1; c8 = 4'd12; a8 = 8'd15; b8 = 8'd17;
    @(posedge clk); #1;
    c8 = 4'd4; a8 = 8'd3; b8 = 8'd4;
    lat = 1;
    while (!r8_vld && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w8.lat", 64'(lat), 64'd9);
    check("w8.res", {56'd0, r8_res}, 64'hFF);
    check("w8.rdy", {63'd0, r8_rdy}, 64'd1);
    @(posedge clk); #1;
    v8 = 1'b0;
    check("w8.held.vld", {63'd0, r8_vld}, 64'd1);
    check("w8.held.res", {56'd0, r8_res}, 64'd7);

    // randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 300));
        2: rb = ra;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 5000));
      run32($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
